ahb_timer: RTL and testbench



---
 rtl/timer_pkg.sv | 45 ++++
 rtl/ahb_timer_if.sv | 23 ++
 rtl/ahb_lite_slv_if.sv | 58 +++++
 rtl/ahb_timer.sv | 125 ++++++++++++
 tb/tb_ahb_timer.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the AHB timer: register offsets, CTRL field positions,
// AHB encodings and byte-lane helpers.
package timer_pkg;

  typedef enum logic [1:0] {
    OFF_CTRL   = 2'd0,
    OFF_COUNT  = 2'd1,
    OFF_CMP    = 2'd2,
    OFF_STATUS = 2'd3
  } reg_off_e;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_IE        = 1;
  localparam int CTRL_AUTO      = 2;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;

  // Only EN/IE/AUTO and PRESC are stored; everything else reads back 0.
  localparam logic [31:0] CTRL_WMASK = 32'h0000_FF07;

  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;

  function automatic logic [3:0] lane_enables(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (hsize)
      3'd0:    be = 4'b0001 << addr_lo;
      3'd1:    be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/ahb_timer_if.sv
// AHB-Lite slave-side bus bundle for the timer (shared slave bus plus its own select).
interface ahb_timer_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic        hready_in;
  logic [31:0] hwdata;
  logic        hready_out;
  logic [31:0] hrdata;
  logic [1:0]  hresp;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hready_in, hwdata,
    input  hready_out, hrdata, hresp
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hready_in, hwdata,
    output hready_out, hrdata, hresp
  );
endinterface

// File: rtl/ahb_lite_slv_if.sv
// Generic AHB-Lite zero-wait slave front end: captures the address phase and
// presents write/read strobes, word offset and byte enables for the data phase.
module ahb_lite_slv_if
  import timer_pkg::*;
(
  input  logic       hclk,
  input  logic       hreset,
  input  logic       hsel_i,
  input  logic [3:0] haddr_i,
  input  logic [1:0] htrans_i,
  input  logic       hwrite_i,
  input  logic [2:0] hsize_i,
  input  logic       hready_i,
  output logic       wr_en_o,
  output logic       rd_en_o,
  output logic [1:0] offset_o,
  output logic [3:0] be_o
);

  logic       valid_q, valid_d;
  logic       write_q, write_d;
  logic [1:0] offset_q, offset_d;
  logic [3:0] be_q, be_d;

  always_comb begin
    valid_d  = valid_q;
    write_d  = write_q;
    offset_d = offset_q;
    be_d     = be_q;
    if (hready_i) begin
      // NONSEQ and SEQ both carry htrans[1]; IDLE/BUSY or no select clear valid.
      valid_d  = hsel_i && ((htrans_i & HTRANS_NONSEQ) != 2'b00);
      write_d  = hwrite_i;
      offset_d = haddr_i[3:2];
      be_d     = lane_enables(hsize_i, haddr_i[1:0]);
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      valid_q  <= 1'b0;
      write_q  <= 1'b0;
      offset_q <= 2'd0;
      be_q     <= 4'd0;
    end else begin
      valid_q  <= valid_d;
      write_q  <= write_d;
      offset_q <= offset_d;
      be_q     <= be_d;
    end
  end

  assign wr_en_o  = valid_q & write_q;
  assign rd_en_o  = valid_q & ~write_q;
  assign offset_o = offset_q;
  assign be_o     = be_q;

endmodule

// File: rtl/ahb_timer.sv
// AHB-Lite timer: prescaled up-counter with compare, auto-reload, sticky
// MATCH flag (W1C) and a registered level interrupt.
module ahb_timer
  import timer_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int PRESC_W = 8
) (
  input  logic       hclk,
  input  logic       hreset,
  ahb_timer_if.slave bus,
  output logic       tint
);

  logic               wr_en, rd_en;
  logic [1:0]         offset;
  logic [3:0]         be;
  logic [31:0]        wmask;
  logic [31:0]        ctrl_q, ctrl_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   cmp_q, cmp_d;
  logic               match_q, match_d;
  logic               tint_q, tint_d;
  logic [PRESC_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [PRESC_W-1:0] presc;
  logic               tick, match_set, match_clr;
  logic               wr_ctrl, wr_count, wr_cmp, wr_status;
  logic [31:0]        rdata;
  logic [27:0]        unused_haddr;

  assign unused_haddr = bus.haddr[31:4];

  ahb_lite_slv_if u_slv (
    .hclk     (hclk),
    .hreset   (hreset),
    .hsel_i   (bus.hsel),
    .haddr_i  (bus.haddr[3:0]),
    .htrans_i (bus.htrans),
    .hwrite_i (bus.hwrite),
    .hsize_i  (bus.hsize),
    .hready_i (bus.hready_in),
    .wr_en_o  (wr_en),
    .rd_en_o  (rd_en),
    .offset_o (offset),
    .be_o     (be)
  );

  assign wmask     = lane_mask(be);
  assign wr_ctrl   = wr_en && (offset == OFF_CTRL);
  assign wr_count  = wr_en && (offset == OFF_COUNT);
  assign wr_cmp    = wr_en && (offset == OFF_CMP);
  assign wr_status = wr_en && (offset == OFF_STATUS);
  assign presc     = ctrl_q[CTRL_PRESC_LSB +: PRESC_W];

  // Prescaler: counts 0..PRESC while enabled, parked at 0 while disabled.
  always_comb begin
    pre_cnt_d = '0;
    tick      = 1'b0;
    if (ctrl_q[CTRL_EN]) begin
      if (pre_cnt_q == presc) tick = 1'b1;
      else                    pre_cnt_d = pre_cnt_q + 1'b1;
    end
  end

  always_comb begin
    count_d   = count_q;
    match_set = 1'b0;
    // A bus write to COUNT swallows a coincident tick entirely.
    if (wr_count) begin
      count_d = merge_bytes(count_q, bus.hwdata, wmask);
    end else if (tick) begin
      if (count_q == cmp_q) begin
        match_set = 1'b1;
        count_d   = ctrl_q[CTRL_AUTO] ? '0 : count_q + 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_comb begin
    ctrl_d    = wr_ctrl ? (merge_bytes(ctrl_q, bus.hwdata, wmask) & CTRL_WMASK) : ctrl_q;
    cmp_d     = wr_cmp ? merge_bytes(cmp_q, bus.hwdata, wmask) : cmp_q;
    match_clr = wr_status && be[0] && bus.hwdata[0];
    match_d   = match_set | (match_q & ~match_clr);
    tint_d    = match_q & ctrl_q[CTRL_IE];
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      ctrl_q    <= '0;
      count_q   <= '0;
      cmp_q     <= '0;
      match_q   <= 1'b0;
      tint_q    <= 1'b0;
      pre_cnt_q <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      count_q   <= count_d;
      cmp_q     <= cmp_d;
      match_q   <= match_d;
      tint_q    <= tint_d;
      pre_cnt_q <= pre_cnt_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      case (offset)
        OFF_CTRL:   rdata = ctrl_q;
        OFF_COUNT:  rdata = count_q;
        OFF_CMP:    rdata = cmp_q;
        OFF_STATUS: rdata = {31'd0, match_q};
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.hrdata     = rdata;
  assign bus.hready_out = 1'b1;
  assign bus.hresp      = HRESP_OKAY;
  assign tint           = tint_q;

endmodule

// File: tb/tb_ahb_timer.sv
// Self-checking bench for ahb_timer: pipelined AHB driver, cycle reference
// model of the timer rules, and per-feature test tasks.
module tb_ahb_timer;

  logic hclk = 1'b0;
  logic hreset;
  logic tint;

  ahb_timer_if bus ();

  ahb_timer #(.CNT_W(32), .PRESC_W(8)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus),
    .tint   (tint)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
  } txn_t;

  txn_t        tx_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          total = 0;
  int          bad   = 0;

  // Reference model state and the write the driver is completing this cycle.
  logic [31:0] m_ctrl, m_count, m_cmp;
  bit          m_match, m_tint;
  int          m_pre;
  bit          mw_valid = 1'b0;
  logic [1:0]  mw_off;
  logic [31:0] mw_mask, mw_data;

  function automatic logic [31:0] byte_mask(input logic [31:0] addr, input logic [2:0] size);
    logic [31:0] m = '0;
    int nb = 1 << size;
    int first = (int'(addr[1:0]) / nb) * nb;
    for (int b = 0; b < 4; b++)
      if (b >= first && b < first + nb) m[b*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [31:0] model_reg(input logic [1:0] off);
    case (off)
      2'd0:    return m_ctrl;
      2'd1:    return m_count;
      2'd2:    return m_cmp;
      default: return {31'd0, m_match};
    endcase
  endfunction

  initial forever begin : ref_model
    bit          tick, set_m, clr_m;
    logic [31:0] nxt, merged;
    @(posedge hclk);
    if (hreset) begin
      m_ctrl = 0; m_count = 0; m_cmp = 0; m_match = 0; m_tint = 0; m_pre = 0;
    end else begin
      tick   = m_ctrl[0] && (m_pre == int'(m_ctrl[15:8]));
      set_m  = 0;
      clr_m  = 0;
      nxt    = m_count;
      m_tint = m_match && m_ctrl[1];
      m_pre  = (!m_ctrl[0] || tick) ? 0 : m_pre + 1;
      if (tick) begin
        nxt = m_count + 32'd1;
        if (m_count == m_cmp) begin
          set_m = 1;
          if (m_ctrl[2]) nxt = 0;
        end
      end
      if (mw_valid) begin
        merged = (model_reg(mw_off) & ~mw_mask) | (mw_data & mw_mask);
        case (mw_off)
          2'd0: m_ctrl = merged & 32'h0000FF07;
          2'd1: begin nxt = merged; set_m = 0; end
          2'd2: m_cmp = merged;
          default: clr_m = mw_mask[0] && mw_data[0];
        endcase
      end
      m_count = nxt;
      m_match = set_m || (m_match && !clr_m);
    end
  end

  task automatic add_wr(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    txn_t t;
    t.wr = 1; t.addr = addr; t.size = size; t.data = data;
    tx_q.push_back(t);
  endtask

  task automatic add_rd(input logic [31:0] addr);
    txn_t t;
    t.wr = 0; t.addr = addr; t.size = 3'd2; t.data = 0;
    tx_q.push_back(t);
  endtask

  // Issues tx_q back-to-back; entered and left #1 after a rising edge.
  task automatic run_q();
    int n = tx_q.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        bus.hsel = 1; bus.htrans = 2'b10; bus.haddr = tx_q[i].addr;
        bus.hwrite = tx_q[i].wr; bus.hsize = tx_q[i].size;
      end else begin
        bus.hsel = 0; bus.htrans = 2'b00; bus.haddr = 0; bus.hwrite = 0; bus.hsize = 0;
      end
      mw_valid = 0;
      if (i > 0 && tx_q[i-1].wr) begin
        bus.hwdata = tx_q[i-1].data;
        mw_valid   = 1;
        mw_off     = tx_q[i-1].addr[3:2];
        mw_mask    = byte_mask(tx_q[i-1].addr, tx_q[i-1].size);
        mw_data    = tx_q[i-1].data;
      end
      @(negedge hclk);
      if (i > 0 && !tx_q[i-1].wr) begin
        got_q.push_back(bus.hrdata);
        exp_q.push_back(model_reg(tx_q[i-1].addr[3:2]));
      end
      @(posedge hclk); #1;
    end
    mw_valid = 0;
    bus.hwdata = 0;
    tx_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge hclk); #1; end
  endtask

  task automatic test_reset();
    logic [31:0] g, e;
    hreset = 1;
    repeat (2) @(posedge hclk);
    #1 hreset = 0;
    @(negedge hclk);
    total++; if (bus.hrdata !== 32'd0) begin bad++; $display("FAIL reset_hrdata: got %h exp 0", bus.hrdata); end
    total++; if (tint !== 1'b0) begin bad++; $display("FAIL reset_tint: got %b exp 0", tint); end
    total++; if (bus.hready_out !== 1'b1) begin bad++; $display("FAIL reset_hready: got %b exp 1", bus.hready_out); end
    total++; if (bus.hresp !== 2'b00) begin bad++; $display("FAIL reset_hresp: got %b exp 0", bus.hresp); end
    @(posedge hclk); #1;
    for (int a = 0; a < 4; a++) add_rd(a * 4);
    run_q();
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== 32'd0 || g !== e) begin bad++; $display("FAIL reset_reg: got %h exp 0 (model %h)", g, e); end
    end
  endtask

  task automatic test_basic_count();
    logic [31:0] g, e;
    add_wr(32'h8, 2, 32'd5);
    add_wr(32'h0, 2, 32'h3);
    for (int k = 0; k < 12; k++) add_rd(32'h4);
    add_rd(32'hC);
    run_q();
    for (int k = 0; k < 12; k++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e || g !== k) begin bad++; $display("FAIL basic_count[%0d]: got %h exp %h (model %h)", k, g, k, e); end
    end
    g = got_q.pop_front(); e = exp_q.pop_front();
    total++; if (g !== 32'd1 || g !== e) begin bad++; $display("FAIL basic_status: got %h exp 1 (model %h)", g, e); end
    @(negedge hclk);
    total++; if (tint !== 1'b1 || tint !== m_tint) begin bad++; $display("FAIL basic_tint: got %b exp 1", tint); end
    @(posedge hclk); #1;
  endtask

  task automatic test_w1c();
    logic [31:0] g, e;
    add_wr(32'hC, 2, 32'd1);
    add_rd(32'hC);
    run_q();
    g = got_q.pop_front(); e = exp_q.pop_front();
    total++; if (g !== 32'd0 || g !== e) begin bad++; $display("FAIL w1c_status: got %h exp 0 (model %h)", g, e); end
    @(negedge hclk);
    total++; if (tint !== 1'b0 || tint !== m_tint) begin bad++; $display("FAIL w1c_tint: got %b exp 0", tint); end
    @(posedge hclk); #1;
  endtask

  task automatic test_prescale_auto();
    logic [31:0] g, e;
    add_wr(32'h0, 2, 32'h0);
    add_wr(32'h4, 2, 32'h0);
    add_wr(32'hC, 2, 32'h1);
    add_wr(32'h8, 2, 32'h2);
    add_wr(32'h0, 2, 32'h0307);
    for (int k = 0; k < 24; k++) add_rd(32'h4);
    add_rd(32'hC);
    run_q();
    for (int k = 0; k < 24; k++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e || g !== (k / 4) % 3) begin bad++; $display("FAIL presc_count[%0d]: got %h exp %h (model %h)", k, g, (k / 4) % 3, e); end
    end
    g = got_q.pop_front(); e = exp_q.pop_front();
    total++; if (g !== 32'd1 || g !== e) begin bad++; $display("FAIL presc_status: got %h exp 1 (model %h)", g, e); end
    @(negedge hclk);
    total++; if (tint !== m_tint) begin bad++; $display("FAIL presc_tint: got %b exp %b", tint, m_tint); end
    @(posedge hclk); #1;
  endtask

  task automatic test_collision();
    logic [31:0] g, e;
    int waited = 0;
    add_wr(32'hC, 2, 32'h1);
    run_q();
    // Wait until the W1C data phase will end exactly on the next match tick.
    while (!(m_pre == 2 && m_count == 32'd2) && waited < 60) begin
      @(posedge hclk); #1;
      waited++;
    end
    if (waited >= 60) begin
      total++; bad++;
      $display("FAIL collision_align: no aligned slot within %0d cycles", waited);
    end
    add_wr(32'hC, 2, 32'h1);
    add_rd(32'hC);
    run_q();
    g = got_q.pop_front(); e = exp_q.pop_front();
    total++; if (g !== 32'd1 || g !== e) begin bad++; $display("FAIL collision_status: got %h exp 1 (model %h)", g, e); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] g, e, addr;
    logic [2:0]  sz;
    add_wr(32'h0, 2, 32'hFFFF_FFF8);
    add_rd(32'h0);
    add_wr(32'h8, 2, 32'h0);
    add_wr(32'h9, 0, 32'h0000_AA00);
    add_rd(32'h8);
    run_q();
    g = got_q.pop_front(); e = exp_q.pop_front();
    total++; if (g !== 32'h0000_FF00 || g !== e) begin bad++; $display("FAIL ctrl_mask: got %h exp 0000ff00 (model %h)", g, e); end
    g = got_q.pop_front(); e = exp_q.pop_front();
    total++; if (g !== 32'h0000_AA00 || g !== e) begin bad++; $display("FAIL byte_cmp: got %h exp 0000aa00 (model %h)", g, e); end
    for (int k = 0; k < 10; k++) begin
      sz   = 3'($urandom_range(0, 2));
      addr = 32'($urandom_range(1, 2) * 4) | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 1));
      add_wr(addr, sz, $urandom);
      add_rd(addr & 32'hC);
    end
    run_q();
    for (int k = 0; k < 10; k++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== e) begin bad++; $display("FAIL rand_lane[%0d]: got %h exp %h", k, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] g, e;
    add_wr(32'h8, 2, 32'h0000_AA00);
    add_wr(32'h0, 2, 32'h1);
    add_wr(32'h4, 2, 32'hFFFF_FFFF);
    add_rd(32'h4);
    add_rd(32'h4);
    run_q();
    g = got_q.pop_front(); e = exp_q.pop_front();
    total++; if (g !== 32'hFFFF_FFFF || g !== e) begin bad++; $display("FAIL b2b_count: got %h exp ffffffff (model %h)", g, e); end
    g = got_q.pop_front(); e = exp_q.pop_front();
    total++; if (g !== 32'd0 || g !== e) begin bad++; $display("FAIL b2b_wrap: got %h exp 0 (model %h)", g, e); end
  endtask

  task automatic test_bus_hygiene();
    logic [31:0] g, e;
    logic [31:0] snap[4];
    add_wr(32'h0, 2, 32'h0);
    run_q();
    for (int a = 0; a < 4; a++) snap[a] = model_reg(2'(a));
    bus.hsel = 1; bus.htrans = 2'b00; bus.hwrite = 1; bus.haddr = 32'h4; bus.hsize = 2;
    @(posedge hclk); #1;
    bus.hwdata = 32'h1234; bus.htrans = 2'b01; bus.haddr = 32'h0;
    @(posedge hclk); #1;
    bus.hsel = 0; bus.htrans = 2'b10; bus.haddr = 32'h8;
    @(posedge hclk); #1;
    bus.htrans = 2'b00; bus.hwrite = 0; bus.haddr = 0;
    @(posedge hclk); #1;
    bus.hwdata = 0;
    for (int a = 0; a < 4; a++) add_rd(a * 4);
    run_q();
    for (int a = 0; a < 4; a++) begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      total++; if (g !== snap[a] || g !== e) begin bad++; $display("FAIL hygiene_reg%0d: got %h exp %h", a, g, snap[a]); end
    end
  endtask

  initial begin
    bus.hsel = 0; bus.haddr = 0; bus.htrans = 0; bus.hwrite = 0;
    bus.hsize = 0; bus.hready_in = 1; bus.hwdata = 0;
    test_reset();
    test_basic_count();
    test_w1c();
    test_prescale_auto();
    test_collision();
    test_byte_lanes();
    test_back_to_back();
    test_bus_hygiene();
    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
